// File: rtl/fp_add_normalize.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fp_add_normalize
//
// Post-add normaliser for the floating-point adder datapath. Takes the raw
// sign / signed exponent / mantissa sum produced by the mantissa add/subtract
// stage and normalises it:
//   - carry-out (in_m[MW] = 1): single right shift, dropped LSB -> out_sticky,
//     exponent incremented with saturation at the positive limit (out_ovf);
//   - zero mantissa: flagged via out_zero, exponent forced to 0;
//   - already normalised (in_m[MW-1] = 1): passed through unchanged;
//   - leading zeros: iterative left shift, one step per clock, exponent
//     decremented per step. If a step would take the exponent below
//     -2^(EW-1), shifting stops with the exponent pinned at that minimum and
//     out_unf set (denormal-like result).
// One operation in flight; valid/ready handshake on both sides.
//
// Optional build macro: FP_NORM_COARSE_EN
//   Defined   : a SHIFT step moves 4 bits while the top nibble of the mantissa
//               is zero and the 4-bit exponent decrement does not underflow;
//               otherwise it moves 1 bit. Results are identical to the
//               default build, only the number of SHIFT cycles differs.
//   Undefined : every SHIFT step moves 1 bit.
//
// Parameters
//   MW : mantissa width including hidden bit (normalised when bit MW-1 = 1)
//   EW : exponent width, two's-complement signed
//   CW : shift-count width, 2^CW > MW
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input operand valid
//   in_ready   : operand can be accepted (high only in IDLE)
//   in_s       : sign of sum, passed through
//   in_e       : signed exponent of sum
//   in_m       : raw mantissa magnitude, bit MW is adder carry-out
//   out_valid  : result valid, held until accepted
//   out_ready  : downstream accepts result
//   out_s      : sign
//   out_e      : adjusted signed exponent
//   out_m      : normalised mantissa
//   out_sticky : LSB dropped by the carry right shift
//   out_zero   : input mantissa was zero
//   out_ovf    : exponent overflow, saturated
//   out_unf    : exponent underflow, shifting stopped
//   out_shift  : total left shift applied (0 for carry/zero/pass-through)
// -----------------------------------------------------------------------------
module fp_add_normalize #(
  parameter int MW = 24,
  parameter int EW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_s,
  input  logic [EW-1:0] in_e,
  input  logic [MW:0]   in_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [MW-1:0] out_m,
  output logic          out_sticky,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_unf,
  output logic [CW-1:0] out_shift
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exponent limits. E_MIN_X is the most negative exponent held at EW+1 bits
  // so that a decrement below it is still representable and comparable.
  localparam logic [EW-1:0]        E_MAX   = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0]        E_MIN   = {1'b1, {(EW-1){1'b0}}};
  localparam logic signed [EW:0]   E_MIN_X = {2'b11, {(EW-1){1'b0}}};
  localparam logic signed [EW:0]   ONE_X   = (EW+1)'(1);
  localparam logic [CW-1:0]        STEP1   = CW'(1);

  state_t        state_q, state_d;
  logic          s_q, s_d;
  logic [EW-1:0] e_q, e_d;
  logic [MW-1:0] m_q, m_d;
  logic          sticky_q, sticky_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [CW-1:0] shift_q, shift_d;

  // Shift-step selection for the current SHIFT cycle.
  logic signed [EW:0] e_x;       // current exponent, sign-extended
  logic signed [EW:0] e_m1;      // exponent after a 1-bit step
  logic               can_step1; // a 1-bit step stays in range
  logic               coarse;    // take a 4-bit step this cycle
  logic [CW-1:0]      step;
  logic [MW-1:0]      m_sh;

`ifdef FP_NORM_COARSE_EN
  localparam logic signed [EW:0] FOUR_X = (EW+1)'(4);
  logic signed [EW:0] e_m4;
`endif

  always_comb begin
    e_x       = {e_q[EW-1], e_q};
    e_m1      = e_x - ONE_X;
    can_step1 = (e_m1 >= E_MIN_X);
`ifdef FP_NORM_COARSE_EN
    // A 4-bit step never overshoots the leading one (top nibble is zero) and
    // is only taken when it cannot underflow; near the exponent floor the
    // engine degrades to 1-bit steps so unf is flagged at the same place as
    // in the 1-bit build.
    e_m4   = e_x - FOUR_X;
    coarse = (m_q[MW-1 -: 4] == 4'b0000) && (e_m4 >= E_MIN_X);
`else
    coarse = 1'b0;
`endif
    step = coarse ? CW'(4) : STEP1;
    m_sh = m_q << step;
  end

  // Next-state and datapath update.
  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    shift_d  = shift_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d      = in_s;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          shift_d  = '0;
          if (in_m[MW]) begin
            // Carry-out: one right shift, keep the dropped bit as sticky.
            m_d      = in_m[MW:1];
            sticky_d = in_m[0];
            if (in_e == E_MAX) begin
              e_d   = E_MAX;
              ovf_d = 1'b1;
            end else begin
              e_d = in_e + EW'(1);
            end
            state_d = DONE;
          end else if (in_m == '0) begin
            m_d     = '0;
            e_d     = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            m_d     = in_m[MW-1:0];
            e_d     = in_e;
            state_d = in_m[MW-1] ? DONE : SHIFT;
          end
        end
      end

      SHIFT: begin
        if (!can_step1) begin
          // Even one more bit would leave the exponent range: stop here with
          // the mantissa unshifted this cycle.
          e_d     = E_MIN;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          m_d     = m_sh;
          e_d     = e_q - EW'(step);
          shift_d = shift_q + step;
          if (m_sh[MW-1]) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      shift_q  <= shift_d;
    end
  end

  // Handshake flags decode the state register directly; the result registers
  // double as output registers and keep their value after acceptance.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_s      = s_q;
  assign out_e      = e_q;
  assign out_m      = m_q;
  assign out_sticky = sticky_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;
  assign out_shift  = shift_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fp_add_normalize
//
// Scoreboard bench for fp_add_normalize. A driver issues operands (directed
// corner cases, then random ones) and pushes the reference-model result into
// a queue; an independent monitor compares every cycle in which out_valid is
// high against the queue head and pops on the handshake. The reference model
// works from leading-zero counts and integer exponent arithmetic.
// -----------------------------------------------------------------------------
module tb_fp_add_normalize;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 5;

  typedef struct {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          sticky;
    logic          zero;
    logic          ovf;
    logic          unf;
    logic [CW-1:0] shift;
    int            lat;      // expected edges accept..valid, -1 = not checked
    int            acc_edge; // edge count at the accept edge
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_s;
  logic [EW-1:0] in_e;
  logic [MW:0]   in_m;
  logic          out_valid;
  logic          out_ready;
  logic          out_s;
  logic [EW-1:0] out_e;
  logic [MW-1:0] out_m;
  logic          out_sticky;
  logic          out_zero;
  logic          out_ovf;
  logic          out_unf;
  logic [CW-1:0] out_shift;

  fp_add_normalize #(.MW(MW), .EW(EW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_e       (in_e),
    .in_m       (in_m),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_e      (out_e),
    .out_m      (out_m),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_shift  (out_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   bp_mode  = 2; // 0 random backpressure, 1 hold off, 2 always ready
  exp_t expq[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: leading-zero count and integer exponent arithmetic.
  function automatic exp_t model(input logic s, input logic [EW-1:0] e, input logic [MW:0] m);
    exp_t          r;
    int            ei;
    int            lz;
    int            sh;
    logic [MW-1:0] mm;
    r = '{default: '0};
    r.s   = s;
    r.lat = 1;
    ei    = int'($signed(e));
    if (m[MW]) begin
      r.m      = m[MW:1];
      r.sticky = m[0];
      if (ei == 127) begin
        r.e   = 8'd127;
        r.ovf = 1'b1;
      end else begin
        r.e = EW'(ei + 1);
      end
    end else if (m == '0) begin
      r.zero = 1'b1;
    end else begin
      mm = m[MW-1:0];
      lz = 0;
      while (!mm[MW-1]) begin
        mm = mm << 1;
        lz++;
      end
      if (ei - lz >= -128) begin
        r.e     = EW'(ei - lz);
        r.m     = m[MW-1:0] << lz;
        r.shift = CW'(lz);
`ifdef FP_NORM_COARSE_EN
        r.lat = 1 + lz / 4 + lz % 4;
`else
        r.lat = 1 + lz;
`endif
      end else begin
        sh      = ei + 128;
        r.e     = 8'h80;
        r.unf   = 1'b1;
        r.m     = m[MW-1:0] << sh;
        r.shift = CW'(sh);
        r.lat   = -1;
      end
    end
    return r;
  endfunction

  // Downstream ready, changed just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (bp_mode == 2) || (bp_mode == 0 && $urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare whenever a result is presented, pop on handshake.
  logic prev_valid = 1'b0;
  int   rise_edge  = 0;
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && out_valid) begin
      if (!prev_valid) rise_edge = edge_cnt;
      if (expq.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        x = expq[0];
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        check("result", 64'({out_s, out_e, out_m, out_sticky, out_zero, out_ovf, out_unf, out_shift}),
              64'({x.s, x.e, x.m, x.sticky, x.zero, x.ovf, x.unf, x.shift}));
        if (!prev_valid && x.lat >= 0)
          check("latency", 64'(rise_edge - x.acc_edge + 1), 64'(x.lat));
        if (out_ready) void'(expq.pop_front());
      end
    end
    prev_valid = rst_n && out_valid;
  end

  task automatic issue(input logic s, input logic [EW-1:0] e, input logic [MW:0] m);
    exp_t x;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("issue_timeout", 64'(in_ready), 64'd1);
      return;
    end
    x        = model(s, e, m);
    in_valid = 1'b1;
    in_s     = s;
    in_e     = e;
    in_m     = m;
    @(posedge clk);
    #1;
    x.acc_edge = edge_cnt;
    expq.push_back(x);
    // Junk on the data inputs while busy must not disturb the operation.
    in_valid = 1'b0;
    in_s     = 1'($urandom);
    in_e     = EW'($urandom);
    in_m     = (MW+1)'($urandom);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    check({name, "_outs"}, 64'({out_s, out_e, out_m, out_sticky, out_zero, out_ovf, out_unf, out_shift}), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) check({name, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int            cat;
    int            pos;
    logic [MW:0]   m;
    logic [EW-1:0] e;
    logic [EW-1:0] e_pick [4];
    int            w;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_s     = 1'b0;
    in_e     = '0;
    in_m     = '0;
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("after_reset");

    // Directed corner cases.
    issue(1'b0, 8'd5,    25'h1800001); // carry with sticky
    issue(1'b1, 8'd40,   25'h0000001); // deepest shift
    issue(1'b1, 8'd77,   25'h0000000); // zero
    issue(1'b0, 8'hFD,   25'h0800000); // pre-normalised, e = -3
    issue(1'b1, 8'd127,  25'h1000003); // carry at max exponent -> ovf
    issue(1'b0, 8'h82,   25'h0000100); // underflow, e = -126
    issue(1'b0, 8'h80,   25'h0400000); // already at floor, cannot shift
    issue(1'b1, 8'h81,   25'h1000000); // carry from -127

    // Backpressure: result must hold for several cycles with in_ready low.
    bp_mode = 1;
    issue(1'b1, 8'd10, 25'h00000F0);
    wait_valid("hold");
    repeat (5) @(negedge clk);
    bp_mode = 2;

    // Reset in the middle of a long shift aborts it with no result.
    issue(1'b0, 8'd40, 25'h0000001);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_shift_reset");
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 8'd40, 25'h0000003);

    // Random operands with random backpressure.
    e_pick[0] = 8'd127;
    e_pick[1] = 8'h80;
    e_pick[2] = 8'h88;
    e_pick[3] = 8'd126;
    bp_mode = 0;
    for (int i = 0; i < 200; i++) begin
      cat = $urandom_range(0, 9);
      if (cat < 2) begin
        m = {1'b1, MW'($urandom)};
      end else if (cat == 2) begin
        m = '0;
      end else if (cat == 3) begin
        m = {2'b01, (MW-1)'($urandom)};
      end else begin
        pos = $urandom_range(0, MW-2);
        m   = ((MW+1)'($urandom) & (((MW+1)'(1) << pos) - (MW+1)'(1))) | ((MW+1)'(1) << pos);
      end
      if ($urandom_range(0, 3) == 0) e = e_pick[$urandom_range(0, 3)];
      else e = EW'($urandom);
      issue(1'($urandom), e, m);
    end

    // Drain.
    bp_mode = 2;
    w = 0;
    while ((expq.size() != 0 || out_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", 64'(expq.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
